// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / decoded-immediate-out handshake bundle.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [31:0]     out_inst;
    logic [2:0]      count;
    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_inst, count
    );
    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_inst, count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV immediate decoder feeding a DEPTH-stage elastic pipeline.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter bit ZIMM_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_ILL} fmt_e;
    localparam bit RV64 = (XLEN == 64);

    logic [31:0]      inst;
    fmt_e             fmt_d;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_d;
    logic [DEPTH:0]   go;
    logic [DEPTH-1:0] vld_q, vld_d, adv, ld;
    logic [2:0]       cnt;
    logic [XLEN-1:0]  imm_q  [DEPTH];
    fmt_e             fmt_q  [DEPTH];
    logic [31:0]      inst_q [DEPTH];

    assign inst = bus.in_inst;

    always_comb begin
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: fmt_d = FMT_I;
            7'b0011011: fmt_d = RV64 ? FMT_I : FMT_ILL;
            7'b0100011: fmt_d = FMT_S;
            7'b1100011: fmt_d = FMT_B;
            7'b0110111, 7'b0010111: fmt_d = FMT_U;
            7'b1101111: fmt_d = FMT_J;
            7'b0110011: fmt_d = FMT_R;
            7'b0111011: fmt_d = RV64 ? FMT_R : FMT_ILL;
            7'b1110011: fmt_d = (ZIMM_EN && inst[14]) ? FMT_Z : FMT_I;
            default:    fmt_d = FMT_ILL;
        endcase
        imm32 = fmt_d == FMT_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                fmt_d == FMT_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                fmt_d == FMT_U ? {inst[31:12], 12'b0} :
                fmt_d == FMT_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                                 {{20{inst[31]}}, inst[31:20]};
        imm_d = fmt_d == FMT_Z ? XLEN'(inst[19:15]) :
                (fmt_d == FMT_R || fmt_d == FMT_ILL) ? '0 : XLEN'($signed(imm32));
    end

    // go[i]: stage i can take new data this cycle; go[DEPTH] is the downstream sink.
    always_comb begin
        go = '0;
        adv = '0;
        ld = '0;
        vld_d = '0;
        cnt = '0;
        go[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = vld_q[i] && go[i+1];
            go[i] = !vld_q[i] || adv[i];
        end
        ld[0] = bus.in_valid && !flush && go[0];
        for (int i = 1; i < DEPTH; i++) ld[i] = adv[i-1];
        for (int i = 0; i < DEPTH; i++) begin
            vld_d[i] = !flush && (ld[i] || (vld_q[i] && !adv[i]));
            cnt = cnt + 3'(vld_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i]  <= '0;
                fmt_q[i]  <= FMT_R;
                inst_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            if (ld[0]) begin
                imm_q[0]  <= imm_d;
                fmt_q[0]  <= fmt_d;
                inst_q[0] <= inst;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ld[i]) begin
                    imm_q[i]  <= imm_q[i-1];
                    fmt_q[i]  <= fmt_q[i-1];
                    inst_q[i] <= inst_q[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = !flush && go[0];
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.out_imm   = imm_q[DEPTH-1];
    assign bus.out_fmt   = fmt_q[DEPTH-1];
    assign bus.out_inst  = inst_q[DEPTH-1];
    assign bus.count     = cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=64 and XLEN=32 instances on one stream, checked against a queue model.
module tb_imm_gen_pipe;
    localparam int DEPTH = 2;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_inst = 0;
    int          n_tests = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64)) b64 ();
    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    assign b64.in_valid = in_valid;
    assign b64.in_inst = in_inst;
    assign b64.out_ready = out_ready;
    assign b32.in_valid = in_valid;
    assign b32.in_inst = in_inst;
    assign b32.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .ZIMM_EN(1)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));
    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .ZIMM_EN(1)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));

    typedef struct { logic [31:0] inst; int t; } ent_t;
    typedef struct { logic [31:0] inst; logic [63:0] imm64; logic [2:0] fmt64; logic [31:0] imm32; logic [2:0] fmt32; int cyc; } out_t;
    ent_t q[$];
    out_t outs[$];
    int   acc_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] w, input bit x64, output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: fmt = 3'd1;
            7'b0011011: fmt = x64 ? 3'd1 : 3'd7;
            7'b0100011: fmt = 3'd2;
            7'b1100011: fmt = 3'd3;
            7'b0110111, 7'b0010111: fmt = 3'd4;
            7'b1101111: fmt = 3'd5;
            7'b0110011: fmt = 3'd0;
            7'b0111011: fmt = x64 ? 3'd0 : 3'd7;
            7'b1110011: fmt = w[14] ? 3'd6 : 3'd1;
            default:    fmt = 3'd7;
        endcase
        case (fmt)
            3'd1:    v = longint'($signed(w[31:20]));
            3'd2:    v = longint'($signed({w[31:25], w[11:7]}));
            3'd3:    v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            3'd4:    v = longint'($signed(w[31:12])) * 4096;
            3'd5:    v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            3'd6:    v = longint'(w[19:15]);
            default: v = 0;
        endcase
        imm = x64 ? v : {32'b0, v[31:0]};
    endfunction

    // An entry becomes visible DEPTH cycles after accept, never sooner than one cycle after its predecessor leaves.
    logic        mr, mv;
    logic [63:0] e64, e32;
    logic [2:0]  f64, f32;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else begin
            mr = !flush && (q.size() < DEPTH || out_ready);
            mv = q.size() > 0 && cyc >= q[0].t;
            chk("in_ready64", 64'(b64.in_ready), 64'(mr));
            chk("in_ready32", 64'(b32.in_ready), 64'(mr));
            chk("out_valid64", 64'(b64.out_valid), 64'(mv));
            chk("out_valid32", 64'(b32.out_valid), 64'(mv));
            chk("count64", 64'(b64.count), 64'(q.size()));
            chk("count32", 64'(b32.count), 64'(q.size()));
            if (mv) begin
                ref_dec(q[0].inst, 1'b1, e64, f64);
                ref_dec(q[0].inst, 1'b0, e32, f32);
                chk("imm64", b64.out_imm, e64);
                chk("fmt64", 64'(b64.out_fmt), 64'(f64));
                chk("inst64", 64'(b64.out_inst), 64'(q[0].inst));
                chk("imm32", 64'(b32.out_imm), e32);
                chk("fmt32", 64'(b32.out_fmt), 64'(f32));
                chk("inst32", 64'(b32.out_inst), 64'(q[0].inst));
            end
            if (mv && out_ready) begin
                outs.push_back('{q[0].inst, b64.out_imm, b64.out_fmt, b32.out_imm, b32.out_fmt, cyc});
                void'(q.pop_front());
                if (q.size() > 0 && q[0].t < cyc + 1) q[0].t = cyc + 1;
            end
            if (flush) q.delete();
            else if (in_valid && mr) begin
                q.push_back('{in_inst, cyc + DEPTH});
                acc_cyc.push_back(cyc);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bit took = 0;
        in_valid = 1;
        in_inst = w;
        for (int k = 0; k < 20 && !took; k++) begin
            @(negedge clk);
            took = b64.in_ready;
            step();
        end
        in_valid = 0;
        chk("push_taken", 64'(took), 64'd1);
    endtask

    task automatic one(input logic [31:0] w, input logic [63:0] x64, input logic [2:0] g64, input logic [31:0] x32, input logic [2:0] g32);
        outs.delete();
        push(w);
        repeat (3) step();
        chk("one_count", 64'(outs.size()), 64'd1);
        if (outs.size() == 1) begin
            chk("one_imm64", outs[0].imm64, x64);
            chk("one_fmt64", 64'(outs[0].fmt64), 64'(g64));
            chk("one_imm32", 64'(outs[0].imm32), 64'(x32));
            chk("one_fmt32", 64'(outs[0].fmt32), 64'(g32));
        end
    endtask

    logic [6:0]  ops [13] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73};
    logic [31:0] s030 [3] = '{32'h42618313, 32'h00428463, 32'h3BF6A26F};
    logic [63:0] e030 [3] = '{64'd1062, 64'd8, 64'd437182};
    logic [2:0]  g030 [3] = '{3'd1, 3'd3, 3'd5};

    initial begin
        #1;
        chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
        chk("rst_count", 64'(b64.count), 64'd0);
        chk("rst_imm", b64.out_imm, 64'd0);
        chk("rst_inst", 64'(b32.out_inst), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        step();

        outs.delete();
        acc_cyc.delete();
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            in_inst = s030[k];
            step();
        end
        in_valid = 0;
        repeat (4) step();
        chk("stream_n", 64'(outs.size()), 64'd3);
        if (outs.size() == 3 && acc_cyc.size() == 3)
            for (int k = 0; k < 3; k++) begin
                chk("stream_imm", outs[k].imm64, e030[k]);
                chk("stream_fmt", 64'(outs[k].fmt64), 64'(g030[k]));
                chk("stream_lat", 64'(outs[k].cyc - acc_cyc[k]), 64'd2);
                chk("stream_b2b", 64'(outs[k].cyc - outs[0].cyc), 64'(k));
            end

        one(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF, 3'd1);
        one(32'h3002D073, 64'd5, 3'd6, 32'd5, 3'd6);
        one(32'h07BF0337, 64'h00000000_07BF0000, 3'd4, 32'h07BF0000, 3'd4);
        one(32'h0010001B, 64'd1, 3'd1, 32'd0, 3'd7);
        one(32'h00000000, 64'd0, 3'd7, 32'd0, 3'd7);
        one(32'h0000003B, 64'd0, 3'd0, 32'd0, 3'd7);
        one(32'h80002073, 64'hFFFFFFFFFFFFF800, 3'd1, 32'hFFFFF800, 3'd1);

        out_ready = 0;
        outs.delete();
        push(32'h00100093);
        push(32'h00200113);
        in_valid = 1;
        in_inst = 32'h00300193;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(b64.in_ready), 64'd0);
            chk("bp_count", 64'(b64.count), 64'd2);
            chk("bp_hold_inst", 64'(b64.out_inst), 64'h00100093);
            chk("bp_hold_imm", b64.out_imm, 64'd1);
            step();
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_third_taken", 64'(b64.in_ready), 64'd1);
        step();
        in_valid = 0;
        repeat (4) step();
        chk("bp_drain_n", 64'(outs.size()), 64'd3);
        if (outs.size() == 3)
            for (int k = 0; k < 3; k++)
                chk("bp_order", 64'(outs[k].inst), 64'(32'h00100093 + (32'h00100000 * k) + (32'h80 * k)));

        out_ready = 0;
        push(32'h00400213);
        push(32'h00500293);
        flush = 1;
        in_valid = 1;
        in_inst = 32'h00600313;
        @(negedge clk);
        chk("fl_in_ready", 64'(b64.in_ready), 64'd0);
        step();
        flush = 0;
        in_valid = 0;
        @(negedge clk);
        chk("fl_out_valid", 64'(b64.out_valid), 64'd0);
        chk("fl_count", 64'(b64.count), 64'd0);
        step();

        push(32'h00700393);
        push(32'h00800413);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("ar_out_valid", 64'(b64.out_valid), 64'd0);
        chk("ar_count", 64'(b64.count), 64'd0);
        chk("ar_imm", b64.out_imm, 64'd0);
        chk("ar_fmt", 64'(b64.out_fmt), 64'd0);
        chk("ar_inst", 64'(b64.out_inst), 64'd0);
        @(posedge clk);
        #3 rst_n = 1;
        outs.delete();
        @(negedge clk);
        chk("ar_in_ready", 64'(b64.in_ready), 64'd1);
        step();
        out_ready = 1;
        push(32'h00900493);
        repeat (3) step();
        chk("ar_first_n", 64'(outs.size()), 64'd1);
        if (outs.size() == 1) chk("ar_first_inst", 64'(outs[0].inst), 64'h00900493);

        for (int k = 0; k < 1500; k++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 50) == 0;
            in_inst = $urandom;
            in_inst[6:0] = ($urandom % 8 == 0) ? 7'($urandom) : ops[$urandom % 13];
            step();
        end
        in_valid = 0;
        flush = 0;
        out_ready = 1;
        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
